// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- iterative radix-2 restoring divider for DIV / DIVU.
//
// Responder side of the EX-stage divide handshake. EX raises div_start and
// holds it, stalling the pipeline, until this block pulses div_ready. The
// result on div_res is then valid and stays valid until the next completion.
//
// Ports:
//   clk         core clock
//   rst         synchronous, active-high reset
//   div_start   request from EX; held high for the whole operation, low = cancel
//   div_signed  1 = DIV (two's complement), 0 = DIVU; sampled at acceptance
//   opr1        dividend; sampled at acceptance
//   opr2        divisor; sampled at acceptance
//   div_ready   one-cycle pulse, result valid
//   div_res     [63:32] remainder (HI), [31:0] quotient (LO)
//   div_busy    high while iterating
// -----------------------------------------------------------------------------
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] opr1,
    input  logic [31:0] opr2,
    output logic        div_ready,
    output logic [63:0] div_res,
    output logic        div_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Magnitude of a possibly-signed operand; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        logic [31:0] m;
        if (sgn && v[31]) begin
            m = ~v + 32'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Conditional 32-bit two's complement negation (wrap-around).
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        logic [31:0] r;
        if (neg) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t      state_r, state_s;
    logic [31:0] divisor_r, divisor_s;
    logic [31:0] quo_r, quo_s;      // dividend bits shift out, quotient bits shift in
    logic [31:0] rem_r, rem_s;
    logic [5:0]  cnt_r, cnt_s;
    logic        qneg_r, qneg_s;
    logic        rneg_r, rneg_s;
    logic        ready_r;
    logic        busy_r;
    logic [63:0] res_r, res_s;

    // 33-bit partial remainder after the shift, and the trial subtraction.
    // Because rem < divisor before the shift, shift < 2*divisor, so a
    // successful trial always fits in 32 bits and trial[32] is the borrow.
    logic [32:0] shift_s;
    logic [32:0] trial_s;

    assign shift_s = {rem_r, quo_r[31]};
    assign trial_s = shift_s - {1'b0, divisor_r};

    // Next-state and datapath update for the IDLE / RUN / DONE sequence.
    always_comb begin
        state_s   = state_r;
        divisor_s = divisor_r;
        quo_s     = quo_r;
        rem_s     = rem_r;
        cnt_s     = cnt_r;
        qneg_s    = qneg_r;
        rneg_s    = rneg_r;
        case (state_r)
            ST_IDLE: begin
                if (div_start) begin
                    divisor_s = mag32(opr2, div_signed);
                    cnt_s     = 6'd0;
                    if (opr2 == 32'h0000_0000) begin
                        // Divide by zero: quotient all ones, remainder is the
                        // raw dividend, so no sign fix-up is applied.
                        quo_s   = 32'hFFFF_FFFF;
                        rem_s   = opr1;
                        qneg_s  = 1'b0;
                        rneg_s  = 1'b0;
                        state_s = ST_DONE;
                    end else begin
                        quo_s   = mag32(opr1, div_signed);
                        rem_s   = 32'h0000_0000;
                        qneg_s  = div_signed & (opr1[31] ^ opr2[31]);
                        rneg_s  = div_signed & opr1[31];
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!div_start) begin
                    // Flush / exception: drop the operation silently.
                    state_s = ST_IDLE;
                end else begin
                    if (!trial_s[32]) begin
                        rem_s = trial_s[31:0];
                        quo_s = {quo_r[30:0], 1'b1};
                    end else begin
                        rem_s = shift_s[31:0];
                        quo_s = {quo_r[30:0], 1'b0};
                    end
                    cnt_s = cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Final signed fix-up, taken from the values about to enter DONE so the
    // result is on div_res in the same cycle as the div_ready pulse.
    always_comb begin
        res_s = {neg_if(rem_s, rneg_s), neg_if(quo_s, qneg_s)};
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            divisor_r <= 32'h0000_0000;
            quo_r     <= 32'h0000_0000;
            rem_r     <= 32'h0000_0000;
            cnt_r     <= 6'd0;
            qneg_r    <= 1'b0;
            rneg_r    <= 1'b0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            res_r     <= 64'h0;
        end else begin
            state_r   <= state_s;
            divisor_r <= divisor_s;
            quo_r     <= quo_s;
            rem_r     <= rem_s;
            cnt_r     <= cnt_s;
            qneg_r    <= qneg_s;
            rneg_r    <= rneg_s;
            ready_r   <= (state_s == ST_DONE);
            busy_r    <= (state_s == ST_RUN);
            if (state_s == ST_DONE) begin
                res_r <= res_s;
            end else begin
                res_r <= res_r;
            end
        end
    end

    assign div_ready = ready_r;
    assign div_busy  = busy_r;
    assign div_res   = res_r;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter -- self-checking bench for div_iter.
// A table of divide vectors is run back-to-back; each launch pushes the
// expected result and completion cycle to a scoreboard queue that is popped
// when div_ready is seen. Hand-written sequences cover abort, mid-run reset
// and reset coinciding with start.
// -----------------------------------------------------------------------------
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] opr1;
    logic [31:0] opr2;
    logic        div_ready;
    logic [63:0] div_res;
    logic        div_busy;

    div_iter dut (
        .clk        (clk),
        .rst        (rst),
        .div_start  (div_start),
        .div_signed (div_signed),
        .opr1       (opr1),
        .opr2       (opr2),
        .div_ready  (div_ready),
        .div_res    (div_res),
        .div_busy   (div_busy)
    );

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    localparam int NV = 13;

    vec_t vecs [NV];
    exp_t sb [$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] res, input int lat);
        exp_t e;
        @(posedge clk);
        #1;
        div_signed = sgn;
        opr1       = a;
        opr2       = b;
        div_start  = 1'b1;
        e.res      = res;
        e.cyc      = cyc + lat;
        sb.push_back(e);
    endtask

    // Wait for div_ready, scrambling operands after acceptance; EX-style
    // handshake drops div_start as soon as the pulse is seen.
    task automatic wait_ready(input int budget, output bit ok, output int busy_cnt);
        ok       = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (i == 1) begin
                opr1 = 32'($urandom);
                opr2 = 32'($urandom);
            end
            if (div_busy) busy_cnt++;
            if (div_ready) begin
                ok        = 1'b1;
                div_start = 1'b0;
                break;
            end
        end
    endtask

    task automatic collect(input string name, input int exp_busy);
        bit   ok;
        int   bc;
        exp_t e;
        wait_ready(60, ok, bc);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.res = 64'h0;
            e.cyc = -1;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            div_start = 1'b0;
            $display("FAIL %s timeout: div_ready never seen, expected at cycle %0d", name, e.cyc);
        end else begin
            check({name, " res"}, div_res, e.res);
            check({name, " ready cycle"}, 64'(cyc), 64'(e.cyc));
            check({name, " busy cycles"}, 64'(bc), 64'(exp_busy));
        end
    endtask

    initial begin
        int t0;
        int r1;
        int r2;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD, 33};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  64'h00000000_80000000, 33};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF, 33};
        vecs[5]  = '{1'b0, 32'h0000_1234,  32'd0,          64'h00001234_FFFFFFFF, 1};
        vecs[6]  = '{1'b1, 32'hFFFF_FF9C,  32'd0,          64'hFFFFFF9C_FFFFFFFF, 1};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001, 33};
        vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  64'hFFFFFFFE_0000000E, 33};
        vecs[9]  = '{1'b0, 32'h8000_0000,  32'd3,          64'h00000002_2AAAAAAA, 33};
        vecs[10] = '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 33};
        vecs[11] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h00000000_00000001, 33};
        vecs[12] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          64'h00000001_7FFFFFFC, 33};

        rst        = 1'b1;
        div_start  = 1'b0;
        div_signed = 1'b0;
        opr1       = 32'h0;
        opr2       = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset div_ready", 64'(div_ready), 64'h0);
        check("reset div_busy", 64'(div_busy), 64'h0);
        check("reset div_res", div_res, 64'h0);

        // Table of vectors, issued back-to-back.
        for (int i = 0; i < NV; i++) begin
            launch(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
            collect($sformatf("vec%0d", i), (vecs[i].lat == 1) ? 0 : 32);
        end

        // Abort at T+10, then restart with 9/3 at T+12.
        @(posedge clk);
        #1;
        div_signed = 1'b0;
        opr1       = 32'd1000;
        opr2       = 32'd7;
        div_start  = 1'b1;
        t0         = cyc;
        repeat (10) @(posedge clk);
        #1;
        div_start = 1'b0;
        @(negedge clk);
        check("abort ready T+10", 64'(div_ready), 64'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort ready T+11", 64'(div_ready), 64'h0);
        check("abort busy T+11", 64'(div_busy), 64'h0);
        check("abort res held", div_res, vecs[NV-1].res);
        launch(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);
        check("restart cycle T+12", 64'(cyc - t0), 64'd12);
        collect("restart", 32);

        // Reset in the middle of RUN.
        @(posedge clk);
        #1;
        div_signed = 1'b0;
        opr1       = 32'd1000;
        opr2       = 32'd3;
        div_start  = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        rst       = 1'b1;
        div_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst div_ready", 64'(div_ready), 64'h0);
        check("midrst div_busy", 64'(div_busy), 64'h0);
        check("midrst div_res", div_res, 64'h0);

        // Back-to-back pair after the reset.
        launch(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 33);
        collect("b2b first", 32);
        r1 = cyc;
        launch(1'b0, 32'd51, 32'd5, 64'h00000001_0000000A, 33);
        collect("b2b second", 32);
        r2 = cyc;
        check("b2b pulse spacing", 64'(r2 - r1), 64'd34);

        // Reset and start together: reset wins, start taken next cycle.
        @(posedge clk);
        #1;
        begin
            exp_t e;
            rst        = 1'b1;
            div_signed = 1'b0;
            opr1       = 32'd40;
            opr2       = 32'd8;
            div_start  = 1'b1;
            e.res      = 64'h00000000_00000005;
            e.cyc      = cyc + 34;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        collect("rst+start", 32);

        check("scoreboard drained", 64'(sb.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
